// File: rtl/cpu_core51_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_core51_if : shared program/data memory bus strobes & address  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
interface cpu_core51_if;
  logic [15:0] addr_bus;
  logic        read_en;
  logic        write_en;
  logic        memory_select;
  logic        PSEN;

  modport master (output addr_bus, read_en, write_en, memory_select, PSEN);
  modport slave  (input  addr_bus, read_en, write_en, memory_select, PSEN);
endinterface
`default_nettype wire

// File: rtl/cpu_core51.sv
`default_nettype none
// +------------------------------------------------------------------+
// | cpu_core51 : reduced 8051-style core, one bus cycle per clk,      |
// |              clock dividers and 4-source vectored interrupts      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module cpu_core51 (
  input  logic         clk,
  input  logic         reset,
  inout  wire  [7:0]   data_bus,
  input  logic         EA,
  input  logic [1:0]   interupt,
  input  logic [1:0]   timer,
  output logic         clk_1M,
  output logic         clk_6M,
  cpu_core51_if.master bus
);
  localparam logic [7:0] c_OP_NOP   = 8'h00;
  localparam logic [7:0] c_OP_LJMP  = 8'h02;
  localparam logic [7:0] c_OP_INC   = 8'h04;
  localparam logic [7:0] c_OP_LCALL = 8'h12;
  localparam logic [7:0] c_OP_RET   = 8'h22;
  localparam logic [7:0] c_OP_RETI  = 8'h32;
  localparam logic [7:0] c_OP_MOVI  = 8'h74;
  localparam logic [7:0] c_OP_MOVAD = 8'hE5;
  localparam logic [7:0] c_OP_MOVDA = 8'hF5;

  typedef enum logic [2:0] {
    S_BOOT = 3'd0, S_FETCH = 3'd1, S_OPER = 3'd2, S_MEM = 3'd3, S_EXEC = 3'd4
  } state_t;

  state_t      r_state;
  logic [15:0] r_pc, r_vector, r_addr;
  logic [7:0]  r_sp, r_acc, r_opcode, r_op_hi, r_op_lo, r_wdata;
  logic        r_in_service, r_irq, r_oper_left, r_mem_idx;
  logic        r_read_en, r_write_en, r_msel, r_psen;
  logic [2:0]  r_div_cnt;
  logic        r_clk_6m, r_clk_1m;

  logic [15:0] w_vector, w_pc_exec;
  logic [7:0]  w_acc_exec;
  logic        w_isr_exec, w_take_irq;

  function automatic logic [1:0] f_num_oper(input logic [7:0] op);
    case (op)
      c_OP_LJMP, c_OP_LCALL:             f_num_oper = 2'd2;
      c_OP_MOVI, c_OP_MOVAD, c_OP_MOVDA: f_num_oper = 2'd1;
      default:                           f_num_oper = 2'd0;
    endcase
  endfunction

  // PSEN is high only for internal program space (EA=1 and below 1000h)
  function automatic logic f_psen(input logic ea, input logic [15:0] a);
    f_psen = ea && (a < 16'h1000);
  endfunction

  always_comb begin
    w_vector = 16'h001B;
    if (interupt[0])      w_vector = 16'h0003;
    else if (timer[0])    w_vector = 16'h000B;
    else if (interupt[1]) w_vector = 16'h0013;
  end

  assign w_take_irq = (|{timer, interupt}) && !r_in_service;

  always_comb begin
    w_pc_exec  = r_pc;
    w_acc_exec = r_acc;
    w_isr_exec = r_in_service;
    if (r_irq) begin
      w_pc_exec = r_vector;
    end else begin
      case (r_opcode)
        c_OP_LJMP, c_OP_LCALL: w_pc_exec  = {r_op_hi, r_op_lo};
        c_OP_INC:              w_acc_exec = r_acc + 8'd1;
        c_OP_MOVI:             w_acc_exec = r_op_lo;
        c_OP_RETI:             w_isr_exec = 1'b0;
        default:               ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_BOOT;
      r_pc         <= 16'h0000;
      r_sp         <= 8'h07;
      r_acc        <= 8'h00;
      r_in_service <= 1'b0;
      r_irq        <= 1'b0;
      r_opcode     <= c_OP_NOP;
      r_op_hi      <= 8'h00;
      r_op_lo      <= 8'h00;
      r_oper_left  <= 1'b0;
      r_mem_idx    <= 1'b0;
      r_vector     <= 16'h0000;
      r_addr       <= 16'h0000;
      r_wdata      <= 8'h00;
      r_read_en    <= 1'b0;
      r_write_en   <= 1'b0;
      r_msel       <= 1'b0;
      r_psen       <= 1'b1;
    end else begin
      // Strobes are single-cycle; each state re-arms the next bus cycle.
      r_read_en  <= 1'b0;
      r_write_en <= 1'b0;
      r_msel     <= 1'b0;
      r_psen     <= 1'b1;
      case (r_state)
        S_BOOT: begin
          r_addr <= r_pc; r_read_en <= 1'b1; r_psen <= f_psen(EA, r_pc);
          r_pc <= r_pc + 16'd1;
          r_state <= S_FETCH;
        end
        S_FETCH: begin
          r_opcode <= data_bus;
          if (f_num_oper(data_bus) != 2'd0) begin
            r_oper_left <= (f_num_oper(data_bus) == 2'd2);
            r_addr <= r_pc; r_read_en <= 1'b1; r_psen <= f_psen(EA, r_pc);
            r_pc <= r_pc + 16'd1;
            r_state <= S_OPER;
          end else if (data_bus == c_OP_RET || data_bus == c_OP_RETI) begin
            r_addr <= {8'h00, r_sp}; r_read_en <= 1'b1; r_msel <= 1'b1;
            r_mem_idx <= 1'b0;
            r_state <= S_MEM;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_OPER: begin
          r_op_hi <= r_op_lo;
          r_op_lo <= data_bus;
          if (r_oper_left) begin
            r_oper_left <= 1'b0;
            r_addr <= r_pc; r_read_en <= 1'b1; r_psen <= f_psen(EA, r_pc);
            r_pc <= r_pc + 16'd1;
          end else begin
            r_mem_idx <= 1'b0;
            case (r_opcode)
              c_OP_MOVAD: begin
                r_addr <= {8'h00, data_bus}; r_read_en <= 1'b1; r_msel <= 1'b1;
                r_state <= S_MEM;
              end
              c_OP_MOVDA: begin
                r_addr <= {8'h00, data_bus}; r_write_en <= 1'b1; r_msel <= 1'b1;
                r_wdata <= r_acc;
                r_state <= S_MEM;
              end
              c_OP_LCALL: begin
                r_addr <= {8'h00, r_sp + 8'd1}; r_write_en <= 1'b1; r_msel <= 1'b1;
                r_wdata <= r_pc[7:0];
                r_sp <= r_sp + 8'd1;
                r_state <= S_MEM;
              end
              default: r_state <= S_EXEC;
            endcase
          end
        end
        S_MEM: begin
          if (r_irq || r_opcode == c_OP_LCALL) begin
            if (!r_mem_idx) begin
              r_addr <= {8'h00, r_sp + 8'd1}; r_write_en <= 1'b1; r_msel <= 1'b1;
              r_wdata <= r_pc[15:8];
              r_sp <= r_sp + 8'd1;
              r_mem_idx <= 1'b1;
            end else begin
              r_state <= S_EXEC;
            end
          end else if (r_opcode == c_OP_RET || r_opcode == c_OP_RETI) begin
            r_sp <= r_sp - 8'd1;
            if (!r_mem_idx) begin
              r_pc[15:8] <= data_bus;
              r_addr <= {8'h00, r_sp - 8'd1}; r_read_en <= 1'b1; r_msel <= 1'b1;
              r_mem_idx <= 1'b1;
            end else begin
              r_pc[7:0] <= data_bus;
              r_state <= S_EXEC;
            end
          end else begin
            if (r_opcode == c_OP_MOVAD) r_acc <= data_bus;
            r_state <= S_EXEC;
          end
        end
        default: begin
          r_acc <= w_acc_exec;
          r_pc  <= w_pc_exec;
          // Interrupt entry replaces the next fetch; the push reuses the LCALL path.
          if (w_take_irq) begin
            r_in_service <= 1'b1;
            r_irq        <= 1'b1;
            r_opcode     <= c_OP_NOP;
            r_vector     <= w_vector;
            r_addr <= {8'h00, r_sp + 8'd1}; r_write_en <= 1'b1; r_msel <= 1'b1;
            r_wdata <= w_pc_exec[7:0];
            r_sp <= r_sp + 8'd1;
            r_mem_idx <= 1'b0;
            r_state <= S_MEM;
          end else begin
            r_in_service <= w_isr_exec;
            r_irq        <= 1'b0;
            r_addr <= w_pc_exec; r_read_en <= 1'b1; r_psen <= f_psen(EA, w_pc_exec);
            r_pc <= w_pc_exec + 16'd1;
            r_state <= S_FETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_div_cnt <= 3'd0;
      r_clk_6m  <= 1'b0;
      r_clk_1m  <= 1'b0;
    end else begin
      r_clk_6m <= ~r_clk_6m;
      if (r_div_cnt == 3'd5) begin
        r_div_cnt <= 3'd0;
        r_clk_1m  <= ~r_clk_1m;
      end else begin
        r_div_cnt <= r_div_cnt + 3'd1;
      end
    end
  end

  assign data_bus          = r_write_en ? r_wdata : 8'hzz;
  assign bus.addr_bus      = r_addr;
  assign bus.read_en       = r_read_en;
  assign bus.write_en      = r_write_en;
  assign bus.memory_select = r_msel;
  assign bus.PSEN          = r_psen;
  assign clk_6M            = r_clk_6m;
  assign clk_1M            = r_clk_1m;
endmodule
`default_nettype wire

// File: tb/tb_cpu_core51.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_cpu_core51 : directed bench with bus-transaction scoreboard    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_cpu_core51;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       ea = 1'b1;
  logic [1:0] interupt = 2'b00;
  logic [1:0] timer = 2'b00;
  logic       clk_1M, clk_6M;
  wire  [7:0] data_bus;
  logic [7:0] rom [0:65535];
  logic [7:0] ram [0:255];
  logic       ram_force = 1'b0;
  logic [7:0] rd_val;
  int         checks = 0;
  int         errors = 0;

  typedef struct packed {
    logic        wr;
    logic        msel;
    logic        psen;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;
  txn_t exp_q[$];

  cpu_core51_if bus ();

  cpu_core51 dut (
    .clk      (clk),
    .reset    (reset),
    .data_bus (data_bus),
    .EA       (ea),
    .interupt (interupt),
    .timer    (timer),
    .clk_1M   (clk_1M),
    .clk_6M   (clk_6M),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  always_comb rd_val = bus.memory_select ? (ram_force ? 8'h50 : ram[bus.addr_bus[7:0]])
                                         : rom[bus.addr_bus];
  assign data_bus = bus.read_en ? rd_val : 8'hzz;

  always @(posedge clk) if (bus.write_en) ram[bus.addr_bus[7:0]] <= data_bus;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog observed=timeout expected=finish");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic wr, input logic msel, input logic [15:0] a, input logic [7:0] d);
    txn_t t;
    t.wr = wr; t.msel = msel; t.addr = a; t.data = d;
    t.psen = msel ? 1'b1 : (ea && (a < 16'h1000));
    exp_q.push_back(t);
  endtask

  task automatic exp_fetch(input logic [15:0] a); push(1'b0, 1'b0, a, 8'h00); endtask
  task automatic exp_rd(input logic [15:0] a);    push(1'b0, 1'b1, a, 8'h00); endtask
  task automatic exp_wr(input logic [15:0] a, input logic [7:0] d); push(1'b1, 1'b1, a, d); endtask

  task automatic run_expect(input int budget);
    txn_t e;
    int   n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.read_en || bus.write_en) begin
        e = exp_q.pop_front();
        chk("strobe_overlap", 32'(bus.read_en & bus.write_en), 32'd0);
        chk("write_en", 32'(bus.write_en), 32'(e.wr));
        chk("memory_select", 32'(bus.memory_select), 32'(e.msel));
        chk("addr_bus", 32'(bus.addr_bus), 32'(e.addr));
        chk("PSEN", 32'(bus.PSEN), 32'(e.psen));
        if (e.wr) chk("wdata", 32'(data_bus), 32'(e.data));
      end
    end
    if (exp_q.size() != 0) begin
      chk("txn_timeout_left", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
  endtask

  task automatic fill_rom(input logic [7:0] v);
    for (int i = 0; i < 65536; i++) rom[i] = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    // Reset values, then all-RET program with RAM returning 50h
    fill_rom(8'h22);
    ram_force = 1'b1;
    #32;
    chk("rst_read_en", 32'(bus.read_en), 32'd0);
    chk("rst_write_en", 32'(bus.write_en), 32'd0);
    chk("rst_addr", 32'(bus.addr_bus), 32'd0);
    chk("rst_msel", 32'(bus.memory_select), 32'd0);
    chk("rst_PSEN", 32'(bus.PSEN), 32'd1);
    chk("rst_clk_6M", 32'(clk_6M), 32'd0);
    chk("rst_clk_1M", 32'(clk_1M), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_fetch(16'h0000); exp_rd(16'h0007); exp_rd(16'h0006);
    exp_fetch(16'h5050); exp_rd(16'h0005); exp_rd(16'h0004);
    exp_fetch(16'h5050); exp_rd(16'h0003); exp_rd(16'h0002);
    exp_fetch(16'h5050); exp_rd(16'h0001); exp_rd(16'h0000);
    exp_fetch(16'h5050); exp_rd(16'h00FF); exp_rd(16'h00FE);
    run_expect(100);

    // MOV A,#A5 ; MOV 30h,A with all program external
    ea = 1'b0;
    ram_force = 1'b0;
    fill_rom(8'h00);
    rom[0] = 8'h74; rom[1] = 8'hA5; rom[2] = 8'hF5; rom[3] = 8'h30;
    do_reset();
    exp_fetch(16'h0000); exp_fetch(16'h0001); exp_fetch(16'h0002); exp_fetch(16'h0003);
    exp_wr(16'h0030, 8'hA5); exp_fetch(16'h0004);
    run_expect(40);

    // LCALL 1234h then RET
    ea = 1'b1;
    fill_rom(8'h00);
    rom[0] = 8'h12; rom[1] = 8'h12; rom[2] = 8'h34; rom[16'h1234] = 8'h22;
    do_reset();
    exp_fetch(16'h0000); exp_fetch(16'h0001); exp_fetch(16'h0002);
    exp_wr(16'h0008, 8'h03); exp_wr(16'h0009, 8'h00);
    exp_fetch(16'h1234); exp_rd(16'h0009); exp_rd(16'h0008); exp_fetch(16'h0003);
    run_expect(60);

    // TF0 beats INT1; INT1 held off until RETI completes
    fill_rom(8'h00);
    rom[16'h000C] = 8'h32;
    do_reset();
    exp_fetch(16'h0000);
    run_expect(10);
    timer = 2'b01;
    interupt = 2'b10;
    exp_wr(16'h0008, 8'h01); exp_wr(16'h0009, 8'h00); exp_fetch(16'h000B);
    run_expect(20);
    timer = 2'b00;
    exp_fetch(16'h000C); exp_rd(16'h0009); exp_rd(16'h0008); exp_fetch(16'h0001);
    exp_wr(16'h0008, 8'h02); exp_wr(16'h0009, 8'h00); exp_fetch(16'h0013);
    run_expect(40);
    interupt = 2'b00;

    // Divider waveforms from reset release
    do_reset();
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      chk("clk_6M", 32'(clk_6M), 32'(k % 2));
      chk("clk_1M", 32'(clk_1M), 32'((k / 6) % 2));
    end

    // Reset during the LCALL push kills the second write
    fill_rom(8'h00);
    rom[0] = 8'h12; rom[1] = 8'h12; rom[2] = 8'h34;
    do_reset();
    exp_fetch(16'h0000); exp_fetch(16'h0001); exp_fetch(16'h0002); exp_wr(16'h0008, 8'h03);
    run_expect(20);
    reset = 1'b0;
    #1;
    chk("midcall_rst_write_en", 32'(bus.write_en), 32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("midcall_hold_write_en", 32'(bus.write_en), 32'd0);
    end
    reset = 1'b1;
    exp_fetch(16'h0000);
    run_expect(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
